// File: rtl/set_scan_ctrl_pkg.sv
// Shared widths, lattice bounds, mode and state encodings for the SET scan controller.
package set_scan_ctrl_pkg;

  localparam int unsigned GRID_MIN   = 1;
  localparam int unsigned GRID_MAX   = 8;
  localparam int unsigned AXIS_W     = 4;
  localparam int unsigned COORD_SZ   = 2 * AXIS_W;
  localparam int unsigned CENTRAL_SZ = 6 * AXIS_W;
  localparam int unsigned RADIUS_SZ  = 3 * AXIS_W;
  localparam int unsigned COVERED_SZ = 3;
  localparam int unsigned MODE_SZ    = 2;
  localparam int unsigned CNT_W      = 7;

  typedef enum logic [MODE_SZ-1:0] {
    MODE_A   = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_TWO = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Lattice point as presented to the PE: x in the upper nibble, y in the lower.
  typedef struct packed {
    logic [AXIS_W-1:0] x;
    logic [AXIS_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/set_hit_sel.sv
// Combinational set-operation selector: mode x per-circle coverage -> candidate hit.
module set_hit_sel
  import set_scan_ctrl_pkg::*;
(
  input  logic [MODE_SZ-1:0]    mode_i,
  input  logic [COVERED_SZ-1:0] covered_i,
  output logic                  hit_c_o
);

  logic a;
  logic b;
  logic c;

  assign {a, b, c} = covered_i;

  always_comb begin
    hit_c_o = 1'b0;
    case (mode_e'(mode_i))
      MODE_A:   hit_c_o = a;
      MODE_AND: hit_c_o = a & b;
      MODE_XOR: hit_c_o = a ^ b;
      MODE_TWO: hit_c_o = (a & b & ~c) | (a & ~b & c) | (~a & b & c);
      default:  hit_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/set_scan_ctrl.sv
// Sweeps the 8x8 lattice for one SET job, counts points matching the latched
// set operation and reports the count with a one-cycle valid pulse.
module set_scan_ctrl
  import set_scan_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [MODE_SZ-1:0]    mode_i,
  input  logic [CENTRAL_SZ-1:0] central_i,
  input  logic [RADIUS_SZ-1:0]  radius_i,
  input  logic [COVERED_SZ-1:0] covered_i,
  output logic [COORD_SZ-1:0]   coord_o,
  output logic [CENTRAL_SZ-1:0] cent_buf_o,
  output logic [RADIUS_SZ-1:0]  r_buf_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [CNT_W-1:0]      candidate_o
);

  state_e             state_q;
  logic [MODE_SZ-1:0] mode_q;
  coord_t             coord_q;
  coord_t             coord_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               hit_c;
  logic               last_c;

  set_hit_sel u_hit_sel (
    .mode_i    (mode_q),
    .covered_i (covered_i),
    .hit_c_o   (hit_c)
  );

  assign coord_o = coord_q;
  assign last_c  = (coord_q.x == AXIS_W'(GRID_MAX)) && (coord_q.y == AXIS_W'(GRID_MAX));

  // Raster step: x advances first, wrapping into the next row.
  always_comb begin
    coord_d = coord_q;
    if (coord_q.x == AXIS_W'(GRID_MAX)) begin
      coord_d.x = AXIS_W'(GRID_MIN);
      coord_d.y = coord_q.y + AXIS_W'(1);
    end else begin
      coord_d.x = coord_q.x + AXIS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      coord_q     <= '0;
      cnt_q       <= '0;
      cent_buf_o  <= '0;
      r_buf_o     <= '0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      candidate_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            mode_q      <= mode_i;
            cent_buf_o  <= central_i;
            r_buf_o     <= radius_i;
            cnt_q       <= '0;
            candidate_o <= '0;
            busy_o      <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          coord_q <= '{x: AXIS_W'(GRID_MIN), y: AXIS_W'(GRID_MIN)};
          state_q <= ST_SCAN;
        end
        // covered_i belongs to the current coord_q; the final point leaves coord_q in place.
        ST_SCAN: begin
          if (hit_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (last_c) begin
            state_q <= ST_DONE;
          end else begin
            coord_q <= coord_d;
          end
        end
        ST_DONE: begin
          candidate_o <= cnt_q;
          valid_o     <= 1'b1;
          busy_o      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Scoreboard bench for set_scan_ctrl with a behavioural PE and a lattice-level reference count.
module tb_set_scan_ctrl;
  import set_scan_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en_i = 1'b0;
  logic [MODE_SZ-1:0]    mode_i = '0;
  logic [CENTRAL_SZ-1:0] central_i = '0;
  logic [RADIUS_SZ-1:0]  radius_i = '0;
  logic [COVERED_SZ-1:0] covered_i;
  logic [COORD_SZ-1:0]   coord_o;
  logic [CENTRAL_SZ-1:0] cent_buf_o;
  logic [RADIUS_SZ-1:0]  r_buf_o;
  logic                  busy_o;
  logic                  valid_o;
  logic [CNT_W-1:0]      candidate_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_cnt_q[$];
  int exp_cyc_q[$];
  int mon_cnt;
  int mon_cyc;

  set_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .mode_i      (mode_i),
    .central_i   (central_i),
    .radius_i    (radius_i),
    .covered_i   (covered_i),
    .coord_o     (coord_o),
    .cent_buf_o  (cent_buf_o),
    .r_buf_o     (r_buf_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .candidate_o (candidate_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic in_circle(int px, int py, int cx, int cy, int r);
    return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= r * r;
  endfunction

  // Behavioural PE driven by whatever the DUT presents.
  always_comb begin
    covered_i[2] = in_circle(int'(coord_o[7:4]), int'(coord_o[3:0]),
                             int'(cent_buf_o[23:20]), int'(cent_buf_o[19:16]), int'(r_buf_o[11:8]));
    covered_i[1] = in_circle(int'(coord_o[7:4]), int'(coord_o[3:0]),
                             int'(cent_buf_o[15:12]), int'(cent_buf_o[11:8]), int'(r_buf_o[7:4]));
    covered_i[0] = in_circle(int'(coord_o[7:4]), int'(coord_o[3:0]),
                             int'(cent_buf_o[7:4]), int'(cent_buf_o[3:0]), int'(r_buf_o[3:0]));
  end

  // Reference: count lattice points satisfying the set rule.
  function automatic int ref_count(int mode, logic [CENTRAL_SZ-1:0] cen, logic [RADIUS_SZ-1:0] rad);
    int n;
    int k;
    logic a, b, c;
    n = 0;
    for (int y = 1; y <= 8; y++) begin
      for (int x = 1; x <= 8; x++) begin
        a = in_circle(x, y, int'(cen[23:20]), int'(cen[19:16]), int'(rad[11:8]));
        b = in_circle(x, y, int'(cen[15:12]), int'(cen[11:8]), int'(rad[7:4]));
        c = in_circle(x, y, int'(cen[7:4]), int'(cen[3:0]), int'(rad[3:0]));
        k = int'(a) + int'(b) + int'(c);
        case (mode)
          0: n += int'(a);
          1: n += int'(a && b);
          2: n += int'(a != b);
          default: n += int'(k == 2);
        endcase
      end
    end
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest pending job.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      checks++;
      if (exp_cnt_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: candidate_o=%0d at cycle %0d with no job pending", candidate_o, cyc);
      end else begin
        mon_cnt = exp_cnt_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        if (int'(candidate_o) != mon_cnt || cyc != mon_cyc || busy_o) begin
          errors++;
          $display("FAIL result: candidate_o=%0d at cycle %0d busy_o=%0b, expected %0d at cycle %0d busy_o=0",
                   candidate_o, cyc, busy_o, mon_cnt, mon_cyc);
        end
      end
    end
  end

  function automatic logic [CENTRAL_SZ-1:0] cen3(int ax, int ay, int bx, int by, int cx, int cy);
    return {4'(ax), 4'(ay), 4'(bx), 4'(by), 4'(cx), 4'(cy)};
  endfunction

  function automatic logic [RADIUS_SZ-1:0] rad3(int ar, int br, int cr);
    return {4'(ar), 4'(br), 4'(cr)};
  endfunction

  // Issue a job to an idle DUT, then scramble the inputs to prove they were latched.
  task automatic start_job(int mode, logic [CENTRAL_SZ-1:0] cen, logic [RADIUS_SZ-1:0] rad, int exp);
    @(negedge clk);
    mode_i    = 2'(mode);
    central_i = cen;
    radius_i  = rad;
    en_i      = 1'b1;
    exp_cnt_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 1 + 66);
    @(negedge clk);
    en_i      = 1'b0;
    mode_i    = 2'($urandom);
    central_i = CENTRAL_SZ'($urandom);
    radius_i  = RADIUS_SZ'($urandom);
    check("busy_after_accept", int'(busy_o), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_cnt_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_cnt_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", exp_cnt_q.size(), n);
      exp_cnt_q.delete();
      exp_cyc_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [CENTRAL_SZ-1:0] cen;
    logic [RADIUS_SZ-1:0]  rad;
    int mode;
    int n0;

    repeat (3) @(negedge clk);
    check("rst_coord", int'(coord_o), 0);
    check("rst_cent_buf", int'(cent_buf_o), 0);
    check("rst_r_buf", int'(r_buf_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_candidate", int'(candidate_o), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases with hand-derived counts.
    start_job(0, cen3(4, 4, 0, 0, 0, 0), rad3(2, 0, 0), 13);
    wait_done();
    start_job(0, cen3(1, 1, 0, 0, 0, 0), rad3(1, 0, 0), 3);
    wait_done();
    start_job(1, cen3(4, 4, 4, 4, 0, 0), rad3(2, 2, 0), 13);
    wait_done();
    start_job(2, cen3(4, 4, 4, 4, 0, 0), rad3(2, 2, 0), 0);
    wait_done();
    start_job(3, cen3(1, 1, 1, 1, 8, 8), rad3(0, 0, 0), 1);
    wait_done();

    // en_i during SCAN with new data is dropped.
    start_job(0, cen3(4, 4, 0, 0, 0, 0), rad3(2, 0, 0), 13);
    repeat (10) @(negedge clk);
    mode_i    = 2'd3;
    central_i = cen3(2, 2, 6, 6, 5, 5);
    radius_i  = rad3(5, 5, 5);
    en_i      = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    wait_done();

    // Reset mid-scan: no result, candidate cleared, then a clean job.
    start_job(1, cen3(4, 4, 5, 5, 0, 0), rad3(3, 3, 0), 99);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt_q.delete();
    exp_cyc_q.delete();
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_candidate", int'(candidate_o), 0);
    repeat (70) @(negedge clk);
    check("midrst_candidate_held", int'(candidate_o), 0);
    start_job(0, cen3(1, 1, 0, 0, 0, 0), rad3(1, 0, 0), 3);
    wait_done();

    // en_i held high: ignored in DONE, taken on the following IDLE cycle (67-cycle spacing).
    cen  = cen3(3, 5, 6, 4, 5, 6);
    rad  = rad3(3, 2, 2);
    mode = 3;
    @(negedge clk);
    mode_i    = 2'(mode);
    central_i = cen;
    radius_i  = rad;
    en_i      = 1'b1;
    n0        = cyc + 1;
    exp_cnt_q.push_back(ref_count(mode, cen, rad));
    exp_cyc_q.push_back(n0 + 66);
    exp_cnt_q.push_back(ref_count(mode, cen, rad));
    exp_cyc_q.push_back(n0 + 67 + 66);
    while (cyc < n0 + 67) @(negedge clk);
    en_i = 1'b0;
    wait_done();

    // Randomized jobs against the reference count.
    for (int j = 0; j < 16; j++) begin
      mode = int'($urandom_range(0, 3));
      cen  = cen3(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      rad  = rad3(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      start_job(mode, cen, rad, ref_count(mode, cen, rad));
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
